// File: rtl/obf_lut_seq.sv
// Programmable obfuscation substitution sequencer: request -> descriptor lookup -> stream of
// (sub, imm) word pairs from a runtime-writable sequence memory.
module obf_lut_seq #(
    parameter int IGU_WIDTH  = 7,
    parameter int KEY_WIDTH  = 4,
    parameter int BANK_BITS  = 1,
    parameter int ADDR_WIDTH = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int LEN_WIDTH  = 4,
    localparam int DESC_AW   = BANK_BITS + IGU_WIDTH,
    localparam int CFG_AW    = (ADDR_WIDTH > DESC_AW) ? ADDR_WIDTH : DESC_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [IGU_WIDTH-1:0]  req_index,
    input  logic [KEY_WIDTH-1:0]  req_key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_sub,
    output logic [OUT_WIDTH-1:0]  out_imm,
    output logic [LEN_WIDTH-1:0]  out_ppc,
    output logic                  out_last,
    output logic                  out_miss,
    input  logic                  flush,
    input  logic                  cfg_we,
    input  logic                  cfg_sel,
    input  logic [CFG_AW-1:0]     cfg_addr,
    input  logic [OUT_WIDTH-1:0]  cfg_wdata,
    output logic                  cfg_ready
);
    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_e;
    state_e state_q, state_d;

    logic [OUT_WIDTH-1:0]  mem_q      [2**ADDR_WIDTH];
    logic [LEN_WIDTH-1:0]  len_mem_q  [2**DESC_AW];
    logic [ADDR_WIDTH-1:0] base_mem_q [2**DESC_AW];
    logic [(2**DESC_AW)-1:0] en_q, en_d;

    logic [DESC_AW-1:0]    didx_q, didx_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [OUT_WIDTH-1:0]  sub_q, sub_d, imm_q, imm_d;
    logic [LEN_WIDTH-1:0]  ppc_q, ppc_d;
    logic                  last_q, last_d, miss_q, miss_d;

    logic [LEN_WIDTH-1:0]  d_len, ppc_nxt, len_m1;
    logic [ADDR_WIDTH-1:0] d_base, base_p1, ptr_nxt, ptr_nxt_p1;
    logic                  mem_we, desc_we;
    logic                  unused_bits;

    assign unused_bits = ^{cfg_wdata, req_key};
    assign mem_we  = cfg_we && cfg_ready && !cfg_sel && !rst;
    assign desc_we = cfg_we && cfg_ready && cfg_sel && !rst;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush beats a simultaneous out_ready
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = flush ? IDLE : EMIT;
            EMIT:    if (flush || (out_ready && last_q)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (state_q == IDLE);
        out_valid = (state_q == EMIT);
        cfg_ready = (state_q == IDLE) && !req_valid;
    end

    // Datapath: descriptor decode and pair fetch
    always_comb begin
        didx_d     = didx_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        sub_d      = sub_q;
        imm_d      = imm_q;
        ppc_d      = ppc_q;
        last_d     = last_q;
        miss_d     = miss_q;
        d_len      = len_mem_q[didx_q];
        d_base     = base_mem_q[didx_q];
        base_p1    = d_base + 1'b1;
        ptr_nxt    = ptr_q + ADDR_WIDTH'(2);
        ptr_nxt_p1 = ptr_nxt + 1'b1;
        ppc_nxt    = ppc_q + 1'b1;
        len_m1     = len_q - 1'b1;
        unique case (state_q)
            IDLE: if (req_valid) didx_d = {req_key[BANK_BITS-1:0], req_index};
            LOOKUP: begin
                ppc_d = '0;
                if (!en_q[didx_q] || d_len == '0) begin
                    sub_d  = '0;
                    imm_d  = '0;
                    last_d = 1'b1;
                    miss_d = 1'b1;
                end else begin
                    ptr_d  = d_base;
                    len_d  = d_len;
                    sub_d  = mem_q[d_base];
                    imm_d  = mem_q[base_p1];
                    last_d = (d_len == LEN_WIDTH'(1));
                    miss_d = 1'b0;
                end
            end
            EMIT: if (out_ready && !last_q && !flush) begin
                ptr_d  = ptr_nxt;
                ppc_d  = ppc_nxt;
                sub_d  = mem_q[ptr_nxt];
                imm_d  = mem_q[ptr_nxt_p1];
                last_d = (ppc_nxt == len_m1);
            end
            default: ;
        endcase
    end

    always_comb begin
        en_d = en_q;
        if (desc_we) en_d[cfg_addr[DESC_AW-1:0]] = cfg_wdata[ADDR_WIDTH+LEN_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q   <= '0;
            didx_q <= '0;
            ptr_q  <= '0;
            len_q  <= '0;
            sub_q  <= '0;
            imm_q  <= '0;
            ppc_q  <= '0;
            last_q <= 1'b0;
            miss_q <= 1'b0;
        end else begin
            en_q   <= en_d;
            didx_q <= didx_d;
            ptr_q  <= ptr_d;
            len_q  <= len_d;
            sub_q  <= sub_d;
            imm_q  <= imm_d;
            ppc_q  <= ppc_d;
            last_q <= last_d;
            miss_q <= miss_d;
        end
    end

    // Storage arrays are not cleared by reset; only the enable bits are
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[cfg_addr[ADDR_WIDTH-1:0]] <= cfg_wdata;
        if (desc_we) begin
            len_mem_q[cfg_addr[DESC_AW-1:0]]  <= cfg_wdata[ADDR_WIDTH +: LEN_WIDTH];
            base_mem_q[cfg_addr[DESC_AW-1:0]] <= cfg_wdata[ADDR_WIDTH-1:0];
        end
    end

    assign out_sub  = sub_q;
    assign out_imm  = imm_q;
    assign out_ppc  = ppc_q;
    assign out_last = last_q;
    assign out_miss = miss_q;
endmodule

// File: tb/tb_obf_lut_seq.sv
// Randomised and directed bench for obf_lut_seq against a table-level model of
// descriptors and sequence memory.
module tb_obf_lut_seq;
    logic        clk = 0, rst = 1;
    logic        req_valid = 0, req_ready;
    logic [6:0]  req_index = 0;
    logic [3:0]  req_key = 0;
    logic        out_valid, out_ready = 0;
    logic [15:0] out_sub, out_imm;
    logic [3:0]  out_ppc;
    logic        out_last, out_miss;
    logic        flush = 0;
    logic        cfg_we = 0, cfg_sel = 0;
    logic [7:0]  cfg_addr = 0;
    logic [15:0] cfg_wdata = 0;
    logic        cfg_ready;

    int checks = 0, errors = 0;

    logic [15:0] mem_m [256];
    bit          en_m  [256];
    int          len_m [256];
    int          base_m[256];

    obf_lut_seq dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_key(req_key), .out_valid(out_valid), .out_ready(out_ready),
        .out_sub(out_sub), .out_imm(out_imm), .out_ppc(out_ppc), .out_last(out_last),
        .out_miss(out_miss), .flush(flush), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
        .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_ready(cfg_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mk_desc(input bit en, input int len, input int base);
        logic [3:0] l;
        logic [7:0] b;
        l = len[3:0];
        b = base[7:0];
        return {3'b000, en, l, b};
    endfunction

    task automatic cfg_write(input bit sel, input int addr, input logic [15:0] data);
        @(negedge clk);
        cfg_we = 1; cfg_sel = sel; cfg_addr = addr[7:0]; cfg_wdata = data;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_idle: got %b expected 1", cfg_ready);
        end
        if (!sel) mem_m[addr & 255] = data;
        else begin
            en_m[addr & 255]   = data[12];
            len_m[addr & 255]  = int'(data[11:8]);
            base_m[addr & 255] = int'(data[7:0]);
        end
        @(negedge clk);
        cfg_we = 0;
    endtask

    // rmode 0: always ready, 1: random ready, 2: ready pattern 1,0,0,1,1,1
    task automatic run_req(input int idx, input int key, input int rmode, input string nm);
        int didx, n, k, cyc, a;
        bit miss, rdy;
        logic [5:0]  pat;
        logic [15:0] es, ei;
        logic [3:0]  ep;
        logic        el;
        pat  = 6'b111001;
        didx = ((key & 1) << 7) | idx;
        miss = !en_m[didx] || len_m[didx] == 0;
        n    = miss ? 1 : len_m[didx];
        @(negedge clk);
        req_index = idx[6:0]; req_key = key[3:0]; req_valid = 1; out_ready = 0;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready: got %b expected 1", nm, req_ready);
        end
        @(negedge clk);
        req_valid = 0;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s lookup_valid: got %b expected 0", nm, out_valid);
        end
        k = 0; cyc = 0;
        while (k < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            case (rmode)
                0:       rdy = 1;
                1:       rdy = ($urandom_range(0, 2) != 0);
                default: rdy = (cyc <= 6) ? pat[cyc-1] : 1'b1;
            endcase
            out_ready = rdy;
            a  = (base_m[didx] + 2 * k) % 256;
            es = miss ? 16'h0 : mem_m[a];
            ei = miss ? 16'h0 : mem_m[(a + 1) % 256];
            ep = k[3:0];
            el = (k == n - 1);
            checks++;
            if (out_valid !== 1'b1 || out_sub !== es || out_imm !== ei || out_ppc !== ep ||
                out_last !== el || out_miss !== miss) begin
                errors++;
                $display("FAIL %s step%0d: got v=%b sub=%h imm=%h ppc=%0d last=%b miss=%b expected v=1 sub=%h imm=%h ppc=%0d last=%b miss=%b",
                         nm, k, out_valid, out_sub, out_imm, out_ppc, out_last, out_miss, es, ei, ep, el, miss);
            end
            if (rdy) k++;
        end
        if (k < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d steps expected %0d", nm, k, n);
        end
        @(negedge clk);
        out_ready = 0;
        checks++;
        if (req_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s post_last: got req_ready=%b out_valid=%b expected 1 0", nm, req_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 0;
        checks++;
        if (out_valid !== 0 || out_last !== 0 || out_miss !== 0 || out_sub !== 0 || out_imm !== 0 ||
            out_ppc !== 0 || req_ready !== 1 || cfg_ready !== 1) begin
            errors++;
            $display("FAIL reset: got v=%b last=%b miss=%b sub=%h imm=%h ppc=%0d rr=%b cr=%b expected 0 0 0 0 0 0 1 1",
                     out_valid, out_last, out_miss, out_sub, out_imm, out_ppc, req_ready, cfg_ready);
        end
    endtask

    task automatic test_miss_unconfigured();
        run_req(27, 0, 0, "miss_unconfigured");
    endtask

    task automatic test_basic();
        cfg_write(0, 5, 16'h543C);
        cfg_write(0, 6, 16'h0000);
        cfg_write(0, 7, 16'h5401);
        cfg_write(0, 8, 16'h20A2);
        cfg_write(1, 27, mk_desc(1, 2, 5));
        run_req(27, 0, 0, "basic");
    endtask

    task automatic test_bank();
        cfg_write(1, 27, mk_desc(0, 2, 5));
        cfg_write(1, 128 + 27, mk_desc(1, 2, 5));
        run_req(27, 1, 0, "bank1_hit");
        run_req(27, 0, 0, "bank0_miss");
        run_req(27, 7, 0, "bank1_upper_key");
    endtask

    task automatic test_wrap();
        cfg_write(0, 255, 16'hAAAA);
        cfg_write(0, 0, 16'h1234);
        cfg_write(1, 40, mk_desc(1, 1, 255));
        run_req(40, 0, 0, "wrap");
    endtask

    task automatic test_stall();
        for (int i = 20; i < 28; i++) cfg_write(0, i, 16'($urandom));
        cfg_write(1, 50, mk_desc(1, 4, 20));
        run_req(50, 0, 2, "stall");
    endtask

    task automatic test_flush();
        @(negedge clk);
        req_index = 7'd50; req_key = 4'd0; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        out_ready = 1;
        cfg_we = 1; cfg_sel = 0; cfg_addr = 8'd5; cfg_wdata = 16'hDEAD;
        checks++;
        if (cfg_ready !== 1'b0 || out_valid !== 1'b1 || out_ppc !== 4'd0) begin
            errors++;
            $display("FAIL flush_emit0: got cr=%b v=%b ppc=%0d expected 0 1 0", cfg_ready, out_valid, out_ppc);
        end
        @(negedge clk);
        cfg_we = 0; flush = 1; out_ready = 1;
        checks++;
        if (out_valid !== 1'b1 || out_ppc !== 4'd1 || out_sub !== mem_m[22]) begin
            errors++;
            $display("FAIL flush_emit1: got v=%b ppc=%0d sub=%h expected 1 1 %h", out_valid, out_ppc, out_sub, mem_m[22]);
        end
        @(negedge clk);
        flush = 0; out_ready = 0;
        checks++;
        if (out_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_drop: got v=%b rr=%b expected 0 1", out_valid, req_ready);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL flush_quiet: got v=%b expected 0", out_valid);
            end
        end
        run_req(27, 1, 0, "after_dropped_cfg");
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req_index = 7'd50; req_key = 4'd0; req_valid = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        out_ready = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 256; i++) en_m[i] = 0;
        checks++;
        if (out_valid !== 0 || out_last !== 0 || out_miss !== 0 || out_sub !== 0 || out_imm !== 0 ||
            out_ppc !== 0 || req_ready !== 1) begin
            errors++;
            $display("FAIL reset_mid: got v=%b last=%b miss=%b sub=%h imm=%h ppc=%0d rr=%b expected 0 0 0 0 0 0 1",
                     out_valid, out_last, out_miss, out_sub, out_imm, out_ppc, req_ready);
        end
        run_req(50, 0, 0, "reset_mid_rereq");
        run_req(27, 1, 0, "reset_mid_bank1");
    endtask

    task automatic test_random();
        int used[$];
        int a, idx, key;
        for (int i = 0; i < 256; i++) cfg_write(0, i, 16'($urandom));
        for (int i = 0; i < 12; i++) begin
            a = $urandom_range(0, 255);
            used.push_back(a);
            cfg_write(1, a, mk_desc($urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 255)));
        end
        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                a   = used[$urandom_range(0, used.size() - 1)];
                idx = a & 127;
                key = ((a >> 7) & 1) | ($urandom_range(0, 7) << 1);
            end else begin
                idx = $urandom_range(0, 127);
                key = $urandom_range(0, 15);
            end
            run_req(idx, key, 1, "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            en_m[i] = 0; len_m[i] = 0; base_m[i] = 0; mem_m[i] = 16'h0;
        end
        test_reset();
        test_miss_unconfigured();
        test_basic();
        test_bank();
        test_wrap();
        test_stall();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/obf_lut_seq.md
Name: obf_lut_seq

Overview:
- Parametrised, programmable successor to the fixed obfuscation substitution LUT.
- Accepts a substitution request (IGU index plus key) from the IGU over a valid/ready handshake, looks up a per-bank sequence descriptor, then streams the substitution sequence one step per handshake, each step a (sub, imm) word pair plus pseudo-PC.
- Descriptor table and sequence memory are runtime-writable through a config port, replacing the hard-coded initial tables and case statement.
- Sits between the obfuscation IGU and the instruction-substitution mux in the OR1200 fetch path.

Parameters:
IGU_WIDTH, 7, width of the substitution index
KEY_WIDTH, 4, width of the obfuscation key
BANK_BITS, 1, number of key LSBs used as bank select; banks = 2**BANK_BITS
ADDR_WIDTH, 8, sequence-memory address width; depth = 2**ADDR_WIDTH words
OUT_WIDTH, 16, sequence word width
LEN_WIDTH, 4, sequence-length field width; maximum steps = 2**LEN_WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_index  in  IGU_WIDTH  substitution index
req_key  in  KEY_WIDTH  obfuscation key
out_valid  out  1  step available
out_ready  in  1  consumer takes step
out_sub  out  OUT_WIDTH  substitution word
out_imm  out  OUT_WIDTH  immediate word
out_ppc  out  LEN_WIDTH  step number within sequence, from 0
out_last  out  1  final step of sequence
out_miss  out  1  index unmapped; execute the original instruction
flush  in  1  abort the current sequence
cfg_we  in  1  config write strobe
cfg_sel  in  1  0 = sequence memory, 1 = descriptor table
cfg_addr  in  max(ADDR_WIDTH, BANK_BITS+IGU_WIDTH)  write address
cfg_wdata  in  OUT_WIDTH  write data; descriptor = {en, len[LEN_WIDTH-1:0], base[ADDR_WIDTH-1:0]} in LSBs
cfg_ready  out  1  config write accepted this cycle

Behaviour:
Interface:
- One clock; reset is synchronous and active-high.

Reset values:
- State IDLE.
- out_valid, out_last, out_miss = 0; out_sub, out_imm, out_ppc = 0.
- All descriptor en bits cleared.
- Sequence memory contents are not cleared.

States:
- IDLE:
  - req_ready = 1.
  - On req_valid, latch index and key, capture bank = key[BANK_BITS-1:0], go to LOOKUP.
- LOOKUP (1 cycle):
  - Read descriptor at {bank, index}.
  - en = 0 or len = 0: load a miss step (sub = imm = 0, ppc = 0, last = 1, miss = 1), go to EMIT.
  - Otherwise: ptr = base, ppc = 0; load sub = mem[ptr], imm = mem[ptr+1], last = (len == 1); go to EMIT.
- EMIT:
  - out_valid = 1; outputs held stable while out_ready = 0.
  - On out_ready with last = 0: ppc += 1, ptr += 2; next pair loaded the following cycle with no bubble.
  - On out_ready with last = 1: go to IDLE.

Latency and throughput:
- Request accepted at cycle T (req_valid and req_ready both high) → first out_valid at T+2.
- Throughput is one step per cycle while out_ready stays high.
- After the last handshake, req_ready is high on the next cycle.

Arithmetic and addressing:
- Address arithmetic is modulo 2**ADDR_WIDTH.
- A sequence that crosses the top of memory wraps to 0; the imm read of a pair at the top address reads word 0.
- last = (ppc == len-1).

flush:
- In LOOKUP or EMIT, next state is IDLE and out_valid drops the next cycle, with no last step emitted.
- In IDLE, flush has no effect.
- flush takes precedence over a simultaneous out_ready.

Config port:
- cfg_ready = (state == IDLE) and not req_valid.
- Writes are performed only when cfg_we and cfg_ready are both high; otherwise they are dropped (the master retries).
- Descriptor writes use cfg_addr[BANK_BITS+IGU_WIDTH-1:0]; upper bits are ignored.

Reset during operation:
- rst has priority over everything.
- Any in-flight sequence is discarded and the output drops on the next cycle.
- Descriptors return to unmapped.

Test Plan:
- Reset, then request index 27 with no config → at T+2 out_valid=1, out_miss=1, out_last=1, sub=imm=0; req_ready high one cycle after the handshake.
- Write mem[5..8] = 0x543C, 0x0000, 0x5401, 0x20A2; write descriptor bank0/idx27 = {en=1, len=2, base=5}; request idx27 key=0 with out_ready held high → steps (0x543C, 0x0000, ppc=0, last=0) at T+2 and (0x5401, 0x20A2, ppc=1, last=1) at T+3.
- Same descriptor in bank1 only; request with key=1 and then key=0 → key=1 streams the sequence, key=0 misses.
- Descriptor base=0xFF, len=1; mem[0xFF]=0xAAAA, mem[0]=0x1234 → sub=0xAAAA, imm=0x1234 (address wrap).
- Four-step sequence with out_ready toggled 1,0,0,1,1,1 → outputs stable during stalls, ppc sequence 0,1,2,3, exactly one out_last.
- During step ppc=1, assert flush with out_ready → out_valid=0 next cycle, no further steps; cfg_we issued in EMIT is dropped (cfg_ready=0) and memory is unchanged; rst asserted mid-sequence → all outputs zero next cycle and a re-request of the index misses.
